uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Synchronous ready/valid FIFO between the UART receiver's `data_out`/`data_out_valid`/`data_out_ready` port and the on-chip consumer. It absorbs bursts of received bytes so that a slow consumer does not stall the receiver. The same block also serves on the transmit side, between a producer and the UART's `data_in` port. It is first-word-fall-through: the head entry is visible on `deq_data` whenever `deq_valid` is high.

## Interface

Parameters:
- `WIDTH`, default 8: entry width in bits.
- `DEPTH`, default 8: number of entries. Must be a power of 2 and at least 2.
- `POINTER_WIDTH`, default `$clog2(DEPTH)`: read/write pointer width. Derived from `DEPTH`; never overridden.

Ports:
- `clk`  in  1  — single clock; all state changes on its rising edge.
- `reset`  in  1  — synchronous, active-high; clears all state at the rising edge where it is sampled high.
- `enq_data`  in  WIDTH  — write data.
- `enq_valid`  in  1  — producer offers `enq_data`.
- `enq_ready`  out  1  — FIFO can accept an entry (not full).
- `deq_data`  out  WIDTH  — head entry.
- `deq_valid`  out  1  — head entry present (not empty).
- `deq_ready`  in  1  — consumer takes the head.
- `count`  out  POINTER_WIDTH+1  — current occupancy, 0..DEPTH.

## Operation

- **Storage:** register array `mem[0..DEPTH-1]`, write pointer `wptr`, read pointer `rptr`, occupancy counter `count` (width POINTER_WIDTH+1, so `DEPTH` is representable).
- **Enqueue** fires when `enq_valid && enq_ready`: `mem[wptr] <= enq_data`, then `wptr <= wptr + 1` (mod DEPTH).
- **Dequeue** fires when `deq_valid && deq_ready`: `rptr <= rptr + 1` (mod DEPTH).
- **Pointer wrap:** pointers wrap naturally from DEPTH-1 to 0. No extra wrap bit; full/empty come from `count`.
- **Count update:**
  - enqueue only: +1
  - dequeue only: −1
  - both or neither: unchanged
- **Flags:**
  - `enq_ready = (count != DEPTH)`
  - `deq_valid = (count != 0)`
  - `deq_data = mem[rptr]` (combinational read of the register array)
- **No combinational path** from `enq_valid` to `enq_ready`/`deq_valid`, or from `deq_ready` to `deq_valid`/`enq_ready`. Both flags depend on `count` only.
- **Full (`count == DEPTH`):** `enq_ready = 0`. An enqueue offered in the same cycle as a dequeue is NOT accepted; it is accepted the following cycle. There is no pass-through when full.
- **Empty (`count == 0`):** `deq_valid = 0`. `deq_ready` is ignored; an enqueue in this cycle does not bypass to the output.
- **`deq_data` while `deq_valid = 0`:** unspecified. Consumers and the bench must not sample it.
- **Reset (including mid-operation):** `wptr = rptr = 0`, `count = 0`, all stored entries discarded. Array contents are not cleared. Any handshake in the reset cycle is ignored.
- **Producer rule:** the producer must hold `enq_data`/`enq_valid` until accepted. The FIFO does not require this, but the UART interfaces it sits between do.

## Timing

- **Reset values:**
  - `count = 0`
  - `enq_ready = 1`
  - `deq_valid = 0`
  - `deq_data` unspecified
  
  These hold from the first edge after `reset` is sampled high.
- **Write-to-read latency:** 1 cycle. An entry accepted at edge N is on `deq_data` with `deq_valid = 1` after edge N.
- **Throughput:** one enqueue and one dequeue per cycle sustained while `0 < count < DEPTH`.
- **`enq_ready` after leaving full:** rises the cycle after the dequeue that leaves full.
- **`deq_valid` after draining:** falls the cycle after the dequeue that empties the FIFO.
- **`count` timing:** registered; reflects all handshakes up to and including the previous edge.

## Test plan

- **Reset state:** drive `reset` high for 1 cycle mid-stream with `count = 5` → next cycle `count = 0`, `enq_ready = 1`, `deq_valid = 0`. A subsequent write of 8'hA5 is read back as 8'hA5.
- **Fill and drain (DEPTH = 8):**
  - Enqueue 8'h21..8'h28 with `deq_ready = 0` → `count` steps 1..8 and `enq_ready = 0` at `count = 8`.
  - A 9th write of 8'hFF held valid is not accepted.
  - Assert `deq_ready` → output is 8'h21..8'h28 in order, then 8'hFF, then `deq_valid = 0`.
- **Full with simultaneous enqueue and dequeue:** at `count = 8`, assert `deq_ready` and `enq_valid` (8'h55) together → cycle 1: dequeue only, `count = 7`. Cycle 2: 8'h55 accepted, `count` stays 7. 8'h55 emerges last.
- **Empty with simultaneous enqueue and `deq_ready`:** at `count = 0`, enqueue 8'h3C with `deq_ready = 1` → no dequeue that cycle. Next cycle `deq_valid = 1`, `deq_data = 8'h3C`, `count = 1`. It is dequeued at the following edge.
- **Wrap-around streaming:** enqueue and dequeue every cycle for 20 entries (8'h00..8'h13) starting from `count = 3` → `count` stays 3 throughout and the output order is preserved across multiple pointer wraps.
- **UART integration:** place the FIFO after the on-chip UART receiver, send bytes 8'h21, 8'h42, 8'h63 serially at 115200 baud (33 MHz clock) with `deq_ready = 0` → `count = 3`, and the bytes dequeue in order with no receiver overrun.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through ready/valid FIFO between a UART and its consumer.
// Ports: clk, reset (sync, active-high), enq_* write side, deq_* read side, count.
module uart_rx_fifo #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 8,
  parameter int POINTER_WIDTH = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         enq_data,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  output logic [WIDTH-1:0]         deq_data,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [POINTER_WIDTH:0]   count
);

  localparam logic [POINTER_WIDTH:0] FULL =
    (POINTER_WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0]         mem [DEPTH];
  logic [POINTER_WIDTH-1:0] wptr;
  logic [POINTER_WIDTH-1:0] rptr;
  logic                     enq_fire;
  logic                     deq_fire;

  // Flags come from the registered count only, so neither
  // handshake input reaches enq_ready or deq_valid.
  assign enq_ready = (count != FULL);
  assign deq_valid = (count != '0);
  assign deq_data  = mem[rptr];

  assign enq_fire = enq_valid && enq_ready;
  assign deq_fire = deq_valid && deq_ready;

  // Pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (enq_fire) wptr <= wptr + 1'b1;
      if (deq_fire) rptr <= rptr + 1'b1;
      unique case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is never cleared; reset only discards entries.
  always_ff @(posedge clk) begin
    if (!reset && enq_fire) mem[wptr] <= enq_data;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, corner
// sequences and random traffic against a queue-based model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] enq_data;
  logic       enq_valid;
  logic       enq_ready;
  logic [7:0] deq_data;
  logic       deq_valid;
  logic       deq_ready;
  logic [3:0] count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q[$];
  logic [7:0] got[$];
  bit         last_enq;

  always #5 clk = ~clk;

  uart_rx_fifo #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .enq_data(enq_data),
    .enq_valid(enq_valid),
    .enq_ready(enq_ready),
    .deq_data(deq_data),
    .deq_valid(deq_valid),
    .deq_ready(deq_ready),
    .count(count)
  );

  typedef struct {
    bit       rst;
    bit       ev;
    bit [7:0] ed;
    bit       dr;
    int       exp_count;
    bit       exp_er;
    bit       exp_dv;
    bit [7:0] exp_dd;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic model_chk();
    chk("m_count", 32'(count), 32'(q.size()));
    chk("m_enq_ready", 32'(enq_ready),
        32'(q.size() != DEPTH));
    chk("m_deq_valid", 32'(deq_valid),
        32'(q.size() != 0));
    if (q.size() != 0)
      chk("m_deq_data", 32'(deq_data), 32'(q[0]));
  endtask

  // One clock: compare against the model, then advance both.
  task automatic cyc();
    bit ef;
    bit df;
    model_chk();
    ef = !reset && enq_valid && (q.size() < DEPTH);
    df = !reset && deq_ready && (q.size() > 0);
    if (df) got.push_back(deq_data);
    @(posedge clk);
    #1;
    if (reset) begin
      q.delete();
    end else begin
      if (df) void'(q.pop_front());
      if (ef) q.push_back(enq_data);
    end
    last_enq = ef;
  endtask

  task automatic idle();
    reset     = 1'b0;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    enq_data  = 8'h00;
  endtask

  task automatic push(input logic [7:0] d);
    enq_valid = 1'b1;
    enq_data  = d;
    deq_ready = 1'b0;
    cyc();
    enq_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    while (deq_valid === 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    deq_ready = 1'b0;
    chk({name, "_drained"}, 32'(deq_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] exp_fd[9];
    int pe;
    int pd;

    vecs[0] = '{1, 0, 8'h00, 0, 0, 1, 0, 8'h00};
    vecs[1] = '{0, 1, 8'hA5, 0, 1, 1, 1, 8'hA5};
    vecs[2] = '{0, 1, 8'h3C, 1, 1, 1, 1, 8'h3C};
    vecs[3] = '{0, 0, 8'h00, 1, 0, 1, 0, 8'h00};
    vecs[4] = '{0, 1, 8'h11, 1, 1, 1, 1, 8'h11};
    vecs[5] = '{0, 1, 8'h22, 0, 2, 1, 1, 8'h11};
    vecs[6] = '{1, 1, 8'h33, 1, 0, 1, 0, 8'h00};
    vecs[7] = '{0, 0, 8'h00, 1, 0, 1, 0, 8'h00};

    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_enq_ready", 32'(enq_ready), 32'd1);
    chk("reset_deq_valid", 32'(deq_valid), 32'd0);

    for (int i = 0; i < 8; i++) begin
      reset     = vecs[i].rst;
      enq_valid = vecs[i].ev;
      enq_data  = vecs[i].ed;
      deq_ready = vecs[i].dr;
      cyc();
      chk($sformatf("vec%0d_count", i), 32'(count),
          32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_enq_ready", i),
          32'(enq_ready), 32'(vecs[i].exp_er));
      chk($sformatf("vec%0d_deq_valid", i),
          32'(deq_valid), 32'(vecs[i].exp_dv));
      if (vecs[i].exp_dv)
        chk($sformatf("vec%0d_deq_data", i),
            32'(deq_data), 32'(vecs[i].exp_dd));
    end
    idle();

    // Reset mid-stream at count 5.
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
    chk("pre_reset_count", 32'(count), 32'd5);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_enq_ready", 32'(enq_ready), 32'd1);
    chk("midrst_deq_valid", 32'(deq_valid), 32'd0);
    push(8'hA5);
    chk("midrst_readback", 32'(deq_data), 32'hA5);
    got.delete();
    drain("midrst");
    chk("midrst_got", 32'(got.size() == 1 && got[0] == 8'hA5),
        32'd1);

    // Fill and drain with a held ninth write.
    got.delete();
    for (int i = 0; i < 8; i++) begin
      push(8'(8'h21 + i));
      chk("fill_count", 32'(count), 32'(i + 1));
    end
    chk("full_enq_ready", 32'(enq_ready), 32'd0);
    enq_valid = 1'b1;
    enq_data  = 8'hFF;
    cyc();
    chk("full_reject_count", 32'(count), 32'd8);
    deq_ready = 1'b1;
    for (int n = 0; n < 30 && got.size() < 9; n++) begin
      cyc();
      if (last_enq) enq_valid = 1'b0;
    end
    enq_valid = 1'b0;
    drain("fill");
    for (int i = 0; i < 8; i++) exp_fd[i] = 8'(8'h21 + i);
    exp_fd[8] = 8'hFF;
    chk("fill_got_size", 32'(got.size()), 32'd9);
    for (int i = 0; i < 9 && i < got.size(); i++)
      chk("fill_order", 32'(got[i]), 32'(exp_fd[i]));

    // Full with simultaneous enqueue and dequeue.
    got.delete();
    for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
    enq_valid = 1'b1;
    enq_data  = 8'h55;
    deq_ready = 1'b1;
    cyc();
    chk("fullsim_c1_count", 32'(count), 32'd7);
    chk("fullsim_c1_taken", 32'(last_enq), 32'd0);
    cyc();
    chk("fullsim_c2_count", 32'(count), 32'd7);
    chk("fullsim_c2_taken", 32'(last_enq), 32'd1);
    enq_valid = 1'b0;
    drain("fullsim");
    chk("fullsim_got_size", 32'(got.size()), 32'd9);
    if (got.size() > 0)
      chk("fullsim_last", 32'(got[got.size()-1]), 32'h55);

    // Empty with simultaneous enqueue and deq_ready.
    got.delete();
    enq_valid = 1'b1;
    enq_data  = 8'h3C;
    deq_ready = 1'b1;
    cyc();
    chk("empty_no_deq", 32'(got.size()), 32'd0);
    chk("empty_deq_valid", 32'(deq_valid), 32'd1);
    chk("empty_deq_data", 32'(deq_data), 32'h3C);
    chk("empty_count", 32'(count), 32'd1);
    enq_valid = 1'b0;
    cyc();
    chk("empty_next_count", 32'(count), 32'd0);
    chk("empty_next_got", 32'(got.size() == 1 && got[0] == 8'h3C),
        32'd1);
    idle();

    // Wrap-around streaming at count 3.
    got.delete();
    for (int i = 0; i < 3; i++) push(8'(8'hE0 + i));
    deq_ready = 1'b1;
    enq_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      enq_data = 8'(i);
      cyc();
      chk("wrap_count", 32'(count), 32'd3);
    end
    enq_valid = 1'b0;
    drain("wrap");
    chk("wrap_got_size", 32'(got.size()), 32'd23);
    for (int i = 0; i < 23 && i < got.size(); i++)
      chk("wrap_order", 32'(got[i]),
          i < 3 ? 32'(8'hE0 + i) : 32'(i - 3));

    // Receiver-paced bytes: ~286 clocks/bit, 10 bits/frame.
    got.delete();
    idle();
    for (int b = 0; b < 3; b++) begin
      repeat (2860) @(posedge clk);
      #1;
      chk("uart_no_overrun", 32'(enq_ready), 32'd1);
      enq_valid = 1'b1;
      enq_data  = (b == 0) ? 8'h21 : (b == 1) ? 8'h42 : 8'h63;
      cyc();
      enq_valid = 1'b0;
    end
    chk("uart_count", 32'(count), 32'd3);
    drain("uart");
    chk("uart_got", 32'(got.size() == 3 && got[0] == 8'h21 &&
        got[1] == 8'h42 && got[2] == 8'h63), 32'd1);

    // Randomised traffic in phases of differing pressure.
    idle();
    for (int ph = 0; ph < 4; ph++) begin
      pe = (ph == 0) ? 80 : (ph == 1) ? 20 : (ph == 2) ? 50 : 95;
      pd = (ph == 0) ? 20 : (ph == 1) ? 80 : (ph == 2) ? 50 : 95;
      for (int i = 0; i < 800; i++) begin
        if (!enq_valid || last_enq) begin
          enq_valid = ($urandom_range(0, 99) < pe);
          enq_data  = 8'($urandom);
        end
        deq_ready = ($urandom_range(0, 99) < pd);
        reset     = ($urandom_range(0, 199) == 0);
        cyc();
      end
    end
    idle();
    cyc();
    model_chk();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
